// File: rtl/reciever_ctrl_pkg.sv
// Shared types and sizing for the receive sequencing controller.
// Packet width derives from the network packet width minus the 16-bit framing overhead.
package reciever_ctrl_pkg;

  localparam int PACKET_WIDTH_BITS = 48;
  localparam int STAT_W_DEFAULT    = 16;

  typedef enum logic [1:0] {HUNT, CLEAR, WAIT} rx_ctrl_state_t;

  function automatic int tmo_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/reciever_out_reg.sv
// Single-entry holding register for recovered packets with valid/ready toward the system
// side; a load request that finds the register full and not draining is reported as a drop.
module reciever_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_req_i,
  input  logic         ready_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         drop_o
);

  logic [W-1:0] data_q;
  logic         valid_q;
  logic         drop_q;
  logic         accept;

  // A draining entry frees the slot in the same cycle, so a load can replace it.
  assign accept = load_req_i && (!valid_q || ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= load_req_i && !accept;
      if (accept) begin
        data_q  <= data_i;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign drop_o  = drop_q;

endmodule

// File: rtl/reciever_controller.sv
// Receive sequencing controller: gates bit strobes into the buffer, clears it after each
// detected frame, waits (bounded) for the unsorter. Statistics under RECIEVER_CTRL_STATS_EN.
module reciever_controller
  import reciever_ctrl_pkg::*;
#(
  parameter int PACKET_BITS    = PACKET_WIDTH_BITS - 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STAT_W         = STAT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bit_valid,
  output logic                   buf_read,
  output logic                   buf_clear,
  input  logic                   buf_valid,
  input  logic                   buf_send,
  input  logic [PACKET_BITS-1:0] buf_packet,
  output logic [PACKET_BITS-1:0] pkt_data,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic                   timeout,
  output logic                   drop,
  output logic                   busy,
  output logic [STAT_W-1:0]      frames_ok,
  output logic [STAT_W-1:0]      frames_dropped,
  output logic [STAT_W-1:0]      timeouts
);

  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  rx_ctrl_state_t   state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pend_q;
  logic             timeout_q;
  logic             capture;
  logic             expire;

  assign capture = (state_q == WAIT) && buf_send;
  assign expire  = (state_q == WAIT) && !buf_send && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        HUNT: begin
          pend_q <= 1'b0;
          if (buf_valid) state_q <= CLEAR;
        end
        CLEAR: begin
          // A bit decided while the buffer is being flushed is replayed on the next cycle.
          pend_q  <= bit_valid;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          pend_q <= 1'b0;
          cnt_q  <= cnt_q + 1'b1;
          if (buf_send) begin
            state_q <= HUNT;
          end else if (expire) begin
            state_q   <= HUNT;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  // Gated by rst_n so every output reads 0 while reset is held.
  assign buf_read  = rst_n && (state_q != CLEAR) && (bit_valid || pend_q);
  assign buf_clear = (state_q == CLEAR);
  assign busy      = (state_q != HUNT);
  assign timeout   = timeout_q;

  reciever_out_reg #(
    .W (PACKET_BITS)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req_i (capture),
    .ready_i    (pkt_ready),
    .data_i     (buf_packet),
    .data_o     (pkt_data),
    .valid_o    (pkt_valid),
    .drop_o     (drop)
  );

`ifdef RECIEVER_CTRL_STATS_EN
  logic [STAT_W-1:0] ok_q, dropped_q, tmo_q;
  logic [STAT_W-1:0] ok_d, dropped_d, tmo_d;
  logic              load_evt, drop_evt;

  assign load_evt = capture && (!pkt_valid || pkt_ready);
  assign drop_evt = capture && pkt_valid && !pkt_ready;

  // Saturating increments: hold at all-ones.
  always_comb begin
    ok_d      = ok_q;
    dropped_d = dropped_q;
    tmo_d     = tmo_q;
    if (load_evt && ok_q != '1)      ok_d      = ok_q + 1'b1;
    if (drop_evt && dropped_q != '1) dropped_d = dropped_q + 1'b1;
    if (expire && tmo_q != '1)       tmo_d     = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q      <= '0;
      dropped_q <= '0;
      tmo_q     <= '0;
    end else begin
      ok_q      <= ok_d;
      dropped_q <= dropped_d;
      tmo_q     <= tmo_d;
    end
  end

  assign frames_ok      = ok_q;
  assign frames_dropped = dropped_q;
  assign timeouts       = tmo_q;
`else
  assign frames_ok      = '0;
  assign frames_dropped = '0;
  assign timeouts       = '0;
`endif

endmodule

// File: tb/tb_reciever_controller.sv
module tb_reciever_controller;

  localparam int PB = 32;
  localparam int T  = 48;
  localparam int SW = 16;
`ifdef RECIEVER_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bit_valid, buf_valid, buf_send, pkt_ready;
  logic [PB-1:0] buf_packet;
  logic          buf_read, buf_clear, pkt_valid, timeout, drop, busy;
  logic [PB-1:0] pkt_data;
  logic [SW-1:0] frames_ok, frames_dropped, timeouts;

  int checks   = 0;
  int failures = 0;
  int exp_ok   = 0;
  int exp_drop = 0;
  int exp_to   = 0;
  int to_at;
  logic [PB-1:0] sb[$];
  logic [PB-1:0] exp_pkt;

  always #5 clk = ~clk;

  reciever_controller #(
    .PACKET_BITS    (PB),
    .TIMEOUT_CYCLES (T),
    .STAT_W         (SW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bit_valid      (bit_valid),
    .buf_read       (buf_read),
    .buf_clear      (buf_clear),
    .buf_valid      (buf_valid),
    .buf_send       (buf_send),
    .buf_packet     (buf_packet),
    .pkt_data       (pkt_data),
    .pkt_valid      (pkt_valid),
    .pkt_ready      (pkt_ready),
    .timeout        (timeout),
    .drop           (drop),
    .busy           (busy),
    .frames_ok      (frames_ok),
    .frames_dropped (frames_dropped),
    .timeouts       (timeouts)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic report(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    failures++;
    $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_stats(input string tag);
    logic [SW-1:0] e_ok, e_drop, e_to;
    e_ok   = SW'(STATS ? exp_ok   : 0);
    e_drop = SW'(STATS ? exp_drop : 0);
    e_to   = SW'(STATS ? exp_to   : 0);
    checks++;
    if (frames_ok !== e_ok) report({tag, "_ok"}, frames_ok, e_ok);
    checks++;
    if (frames_dropped !== e_drop) report({tag, "_drop"}, frames_dropped, e_drop);
    checks++;
    if (timeouts !== e_to) report({tag, "_to"}, timeouts, e_to);
  endtask

  task automatic detect();
    buf_valid = 1'b1;
    tick();
    buf_valid = 1'b0;
    checks++;
    if (buf_clear !== 1'b1) report("clear_after_detect", buf_clear, 1'b1);
    tick();
    checks++;
    if (buf_clear !== 1'b0) report("clear_one_cycle", buf_clear, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bit_valid = 1'b1; buf_valid = 1'b0; buf_send = 1'b0;
    pkt_ready = 1'b0; buf_packet = '0;
    #1;
    checks++;
    if (buf_read !== 1'b0) report("rst_buf_read", buf_read, 1'b0);
    tick(); tick();
    checks++;
    if (busy !== 1'b0) report("rst_busy", busy, 1'b0);
    checks++;
    if (pkt_valid !== 1'b0) report("rst_pkt_valid", pkt_valid, 1'b0);
    checks++;
    if (buf_clear !== 1'b0) report("rst_clear", buf_clear, 1'b0);
    checks++;
    if (timeout !== 1'b0) report("rst_timeout", timeout, 1'b0);
    checks++;
    if (drop !== 1'b0) report("rst_drop", drop, 1'b0);
    check_stats("rst");
    rst_n = 1'b1;
    tick();
    checks++;
    if (buf_read !== 1'b1) report("hunt_read_fwd", buf_read, 1'b1);
    bit_valid = 1'b0;
    #1;
    checks++;
    if (buf_read !== 1'b0) report("hunt_read_idle", buf_read, 1'b0);

    buf_valid = 1'b1;
    tick();
    buf_valid = 1'b0;
    bit_valid = 1'b1;
    #1;
    checks++;
    if (buf_clear !== 1'b1) report("clear_asserted", buf_clear, 1'b1);
    checks++;
    if (buf_read !== 1'b0) report("clear_no_read", buf_read, 1'b0);
    tick();
    bit_valid = 1'b0;
    #1;
    checks++;
    if (buf_read !== 1'b1) report("pending_read", buf_read, 1'b1);
    checks++;
    if (busy !== 1'b1) report("wait_busy", busy, 1'b1);
    tick();
    checks++;
    if (buf_read !== 1'b0) report("pending_once", buf_read, 1'b0);
    repeat (37) tick();
    checks++;
    if (pkt_valid !== 1'b0) report("pre_send_valid", pkt_valid, 1'b0);
    buf_send = 1'b1; buf_packet = 32'hA5A5_A5A5;
    sb.push_back(buf_packet);
    tick();
    buf_send = 1'b0;
    exp_ok++;
    exp_pkt = sb[0];
    checks++;
    if (pkt_valid !== 1'b1) report("clean_valid", pkt_valid, 1'b1);
    checks++;
    if (pkt_data !== exp_pkt) report("clean_data", pkt_data, exp_pkt);
    checks++;
    if (busy !== 1'b0) report("clean_hunt", busy, 1'b0);
    check_stats("clean");
    $display("frame 1 clean data=%0h", pkt_data);

    detect();
    repeat (5) tick();
    buf_send = 1'b1; buf_packet = 32'h1234_5678;
    tick();
    buf_send = 1'b0;
    exp_drop++;
    exp_pkt = sb[0];
    checks++;
    if (drop !== 1'b1) report("bp_drop", drop, 1'b1);
    checks++;
    if (pkt_data !== exp_pkt) report("bp_held", pkt_data, exp_pkt);
    checks++;
    if (pkt_valid !== 1'b1) report("bp_valid", pkt_valid, 1'b1);
    check_stats("bp");
    tick();
    checks++;
    if (drop !== 1'b0) report("bp_drop_pulse", drop, 1'b0);
    $display("frame 2 dropped, held=%0h", pkt_data);

    detect();
    repeat (5) tick();
    buf_send = 1'b1; buf_packet = 32'hDEAD_BEEF; pkt_ready = 1'b1;
    sb.push_back(buf_packet);
    tick();
    buf_send = 1'b0; pkt_ready = 1'b0;
    void'(sb.pop_front());
    exp_ok++;
    exp_pkt = sb[0];
    checks++;
    if (drop !== 1'b0) report("rdy_no_drop", drop, 1'b0);
    checks++;
    if (pkt_data !== exp_pkt) report("rdy_data", pkt_data, exp_pkt);
    checks++;
    if (pkt_valid !== 1'b1) report("rdy_valid", pkt_valid, 1'b1);
    check_stats("rdy");
    $display("frame 3 loaded data=%0h", pkt_data);
    pkt_ready = 1'b1;
    tick();
    pkt_ready = 1'b0;
    void'(sb.pop_front());
    checks++;
    if (pkt_valid !== 1'b0) report("drain_valid", pkt_valid, 1'b0);

    detect();
    to_at = 0;
    for (int k = 1; k <= T + 4 && to_at == 0; k++) begin
      tick();
      if (timeout) to_at = k;
    end
    exp_to++;
    checks++;
    if (to_at !== T) report("timeout_cycle", to_at, T);
    checks++;
    if (busy !== 1'b0) report("timeout_hunt", busy, 1'b0);
    checks++;
    if (pkt_valid !== 1'b0) report("timeout_pkt_valid", pkt_valid, 1'b0);
    check_stats("timeout");
    tick();
    checks++;
    if (timeout !== 1'b0) report("timeout_pulse", timeout, 1'b0);
    $display("frame 4 timeout after %0d cycles", to_at);

    detect();
    repeat (T - 1) tick();
    buf_send = 1'b1; buf_packet = 32'h0BAD_F00D;
    sb.push_back(buf_packet);
    tick();
    buf_send = 1'b0;
    exp_ok++;
    exp_pkt = sb[0];
    checks++;
    if (timeout !== 1'b0) report("edge_no_timeout", timeout, 1'b0);
    checks++;
    if (pkt_valid !== 1'b1) report("edge_valid", pkt_valid, 1'b1);
    checks++;
    if (pkt_data !== exp_pkt) report("edge_data", pkt_data, exp_pkt);
    check_stats("edge");
    $display("frame 5 send on expiry data=%0h", pkt_data);

    detect();
    repeat (19) tick();
    rst_n = 1'b0; bit_valid = 1'b1;
    #1;
    sb.delete();
    exp_ok = 0; exp_drop = 0; exp_to = 0;
    checks++;
    if (pkt_valid !== 1'b0) report("mid_rst_valid", pkt_valid, 1'b0);
    checks++;
    if (pkt_data !== 32'h0) report("mid_rst_data", pkt_data, 32'h0);
    checks++;
    if (buf_read !== 1'b0) report("mid_rst_read", buf_read, 1'b0);
    checks++;
    if (busy !== 1'b0) report("mid_rst_busy", busy, 1'b0);
    check_stats("mid_rst");
    tick();
    rst_n = 1'b1; bit_valid = 1'b0;
    tick();
    buf_send = 1'b1; buf_packet = 32'h5555_AAAA;
    tick();
    buf_send = 1'b0;
    checks++;
    if (pkt_valid !== 1'b0) report("spurious_valid", pkt_valid, 1'b0);
    checks++;
    if (busy !== 1'b0) report("spurious_busy", busy, 1'b0);
    check_stats("spurious");
    $display("reset mid-WAIT, spurious send ignored");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
